// File: rtl/overlay_pkg.sv
// Shared constants and types for the glyph overlay path.
//   GLYPH_W/GLYPH_H : glyph size in font pixels
//   GLYPH_WORDS     : ROM bits per glyph (one bit per font pixel)
//   FONT_ADDR_W     : font ROM address width
//   RGB_W           : pixel colour width
//   pix_side_t      : per-pixel sideband carried alongside the ROM lookup
package overlay_pkg;

    localparam int unsigned GLYPH_W     = 8;
    localparam int unsigned GLYPH_H     = 8;
    localparam int unsigned GLYPH_WORDS = 64;
    localparam int unsigned GLYPH_IDX_W = 3;
    localparam int unsigned FONT_ADDR_W = 10;
    localparam int unsigned RGB_W       = 24;

    typedef struct packed {
        logic             de;
        logic             in_box;
        logic [RGB_W-1:0] rgb;
    } pix_side_t;

endpackage

// File: rtl/glyph_blink_ctrl.sv
// Frame-based blink generator for the glyph overlay.
//   clk_50MHz   : pixel clock
//   reset       : asynchronous active-high reset
//   frame_start : one-cycle pulse per frame; all state changes happen here
//   blink_en    : enables blinking; when low the glyph is held visible
//   blink_phase : 1 = glyph visible, 0 = glyph hidden
module glyph_blink_ctrl #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic frame_start,
    input  logic blink_en,
    output logic blink_phase
);

    localparam bit          BLINK_ON = (BLINK_FRAMES != 0);
    // Wraps harmlessly when BLINK_FRAMES is 0; never used in that case.
    localparam logic [15:0] LAST_CNT = 16'(BLINK_FRAMES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        blink_phase_q, blink_phase_d;

    always_comb begin
        cnt_d         = cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            if (blink_en && BLINK_ON) begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d         = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end else begin
                cnt_d         = '0;
                blink_phase_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;

endmodule

// File: rtl/glyph_overlay_renderer.sv
// Renders one scaled 8x8 glyph from a bit-per-pixel font ROM over the video stream.
//   clk_50MHz, reset        : pixel clock, asynchronous active-high reset
//   offset, frame_start     : glyph base address, latched once per frame
//   blink_en                : enables frame-based blinking
//   de_in/hcount_in/
//   vcount_in/rgb_in        : incoming pixel
//   rom_addr/rom_data       : font ROM lookup (registered ROM, one cycle read)
//   de_out/rgb_out/
//   glyph_active            : outgoing pixel, fixed two-cycle latency
module glyph_overlay_renderer
    import overlay_pkg::*;
#(
    parameter int unsigned      X_POS        = 16,
    parameter int unsigned      Y_POS        = 16,
    parameter int unsigned      SCALE_LOG2   = 2,
    parameter int unsigned      CNT_W        = 12,
    parameter logic [RGB_W-1:0] FG_COLOR     = 24'hFFFFFF,
    parameter int unsigned      BLINK_FRAMES = 30
) (
    input  logic                   clk_50MHz,
    input  logic                   reset,
    input  logic [FONT_ADDR_W-1:0] offset,
    input  logic                   frame_start,
    input  logic                   blink_en,
    input  logic                   de_in,
    input  logic [CNT_W-1:0]       hcount_in,
    input  logic [CNT_W-1:0]       vcount_in,
    input  logic [RGB_W-1:0]       rgb_in,
    output logic [FONT_ADDR_W-1:0] rom_addr,
    input  logic                   rom_data,
    output logic                   de_out,
    output logic [RGB_W-1:0]       rgb_out,
    output logic                   glyph_active
);

    localparam int unsigned    BOX_W = GLYPH_W << SCALE_LOG2;
    localparam int unsigned    BOX_H = GLYPH_H << SCALE_LOG2;
    localparam logic [CNT_W-1:0] X_LO = CNT_W'(X_POS);
    localparam logic [CNT_W-1:0] X_HI = CNT_W'(X_POS + BOX_W);
    localparam logic [CNT_W-1:0] Y_LO = CNT_W'(Y_POS);
    localparam logic [CNT_W-1:0] Y_HI = CNT_W'(Y_POS + BOX_H);

    logic [FONT_ADDR_W-1:0] offset_q, offset_d;
    logic [FONT_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    pix_side_t              s0_q, s0_d;
    pix_side_t              s1_q, s1_d;
    logic                   de_out_q, de_out_d;
    logic                   glyph_active_q, glyph_active_d;
    logic [RGB_W-1:0]       rgb_out_q, rgb_out_d;

    logic                   blink_phase;
    logic [CNT_W-1:0]       dx, dy;
    logic [GLYPH_IDX_W-1:0] col, row;
    logic                   in_box;

    glyph_blink_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .frame_start (frame_start),
        .blink_en    (blink_en),
        .blink_phase (blink_phase)
    );

    always_comb begin
        // Offset only moves at frame boundaries so a glyph never tears mid-frame.
        offset_d = frame_start ? offset : offset_q;

        dx     = hcount_in - X_LO;
        dy     = vcount_in - Y_LO;
        col    = dx[SCALE_LOG2 +: GLYPH_IDX_W];
        row    = dy[SCALE_LOG2 +: GLYPH_IDX_W];
        in_box = de_in
                 && (hcount_in >= X_LO) && (hcount_in < X_HI)
                 && (vcount_in >= Y_LO) && (vcount_in < Y_HI);

        // Plain 10-bit wrap: unaligned offsets may legitimately straddle glyphs.
        rom_addr_d = offset_q + FONT_ADDR_W'({row, col});

        s0_d.de     = de_in;
        s0_d.in_box = in_box;
        s0_d.rgb    = rgb_in;
        s1_d        = s0_q;

        de_out_d       = s1_q.de;
        glyph_active_d = s1_q.in_box;
        rgb_out_d      = (s1_q.in_box && rom_data && blink_phase) ? FG_COLOR : s1_q.rgb;
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            offset_q       <= '0;
            rom_addr_q     <= '0;
            s0_q           <= '0;
            s1_q           <= '0;
            de_out_q       <= 1'b0;
            glyph_active_q <= 1'b0;
            rgb_out_q      <= '0;
        end else begin
            offset_q       <= offset_d;
            rom_addr_q     <= rom_addr_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            de_out_q       <= de_out_d;
            glyph_active_q <= glyph_active_d;
            rgb_out_q      <= rgb_out_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign de_out       = de_out_q;
    assign glyph_active = glyph_active_q;
    assign rgb_out      = rgb_out_q;

endmodule

// File: tb/tb_glyph_overlay_renderer.sv
// Bench for glyph_overlay_renderer: directed address/edge cases plus randomized
// pixels, checked against a frame-level reference model with a bit-array font ROM.
module tb_glyph_overlay_renderer;

    localparam int          XP = 16;
    localparam int          YP = 16;
    localparam int          SL = 2;
    localparam int          CW = 12;
    localparam int          BF = 2;
    localparam logic [23:0] FG = 24'hFFFFFF;

    logic        clk_50MHz;
    logic        reset;
    logic [9:0]  offset;
    logic        frame_start;
    logic        blink_en;
    logic        de_in;
    logic [11:0] hcount_in;
    logic [11:0] vcount_in;
    logic [23:0] rgb_in;
    logic [9:0]  rom_addr;
    logic        rom_data;
    logic        de_out;
    logic [23:0] rgb_out;
    logic        glyph_active;

    glyph_overlay_renderer #(
        .X_POS        (XP),
        .Y_POS        (YP),
        .SCALE_LOG2   (SL),
        .CNT_W        (CW),
        .FG_COLOR     (FG),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .offset       (offset),
        .frame_start  (frame_start),
        .blink_en     (blink_en),
        .de_in        (de_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .rgb_in       (rgb_in),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .de_out       (de_out),
        .rgb_out      (rgb_out),
        .glyph_active (glyph_active)
    );

    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    // Registered font ROM.
    bit rom_mem [0:1023];
    always @(posedge clk_50MHz) rom_data <= rom_mem[rom_addr];

    typedef struct {
        bit          de;
        bit          inb;
        logic [23:0] rgb;
        int          addr;
    } ent_t;

    int   n_cmp;
    int   n_bad;
    int   off_m;    // offset seen by the pipeline
    int   n_m;      // consecutive blink-enabled frame starts
    ent_t older;    // pixel sampled two edges ago
    ent_t newer;    // pixel sampled one edge ago

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t model_pixel();
        ent_t e;
        int   hx, vy, col, row;
        hx    = int'(hcount_in);
        vy    = int'(vcount_in);
        e.de  = de_in;
        e.inb = de_in && hx >= XP && hx < XP + (8 << SL) && vy >= YP && vy < YP + (8 << SL);
        e.rgb = rgb_in;
        col   = (((hx - XP) & 4095) / (1 << SL)) % 8;
        row   = (((vy - YP) & 4095) / (1 << SL)) % 8;
        e.addr = (off_m + row * 8 + col) % 1024;
        return e;
    endfunction

    task automatic model_clear();
        off_m = 0;
        n_m   = 0;
        older = '{de: 0, inb: 0, rgb: 24'h0, addr: 0};
        newer = older;
    endtask

    task automatic step();
        ent_t        cur;
        bit          phase;
        logic [23:0] exp_rgb;
        @(posedge clk_50MHz);
        cur     = model_pixel();
        phase   = ((n_m / BF) % 2) == 0;
        exp_rgb = (older.inb && rom_mem[older.addr] && phase) ? FG : older.rgb;
        #1;
        check_eq("rom_addr", 32'(rom_addr), 32'(cur.addr));
        check_eq("de_out", 32'(de_out), 32'(older.de));
        check_eq("glyph_active", 32'(glyph_active), 32'(older.inb));
        check_eq("rgb_out", 32'(rgb_out), 32'(exp_rgb));
        older = newer;
        newer = cur;
        if (frame_start) begin
            off_m = int'(offset);
            n_m   = blink_en ? n_m + 1 : 0;
        end
    endtask

    task automatic drive(input bit fs, input int off, input bit be, input bit de,
                         input int h, input int v, input logic [23:0] rgb);
        frame_start = fs;
        offset      = 10'(off);
        blink_en    = be;
        de_in       = de;
        hcount_in   = 12'(h);
        vcount_in   = 12'(v);
        rgb_in      = rgb;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
        check_eq({tag, "_de_out"}, 32'(de_out), 32'h0);
        check_eq({tag, "_glyph_active"}, 32'(glyph_active), 32'h0);
        check_eq({tag, "_rgb_out"}, 32'(rgb_out), 32'h0);
    endtask

    task automatic drive_random();
        int h, v;
        h = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 63));
        v = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 63));
        drive($urandom_range(0, 5) == 0,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'(offset),
              $urandom_range(0, 15) != 0,
              $urandom_range(0, 7) != 0,
              h, v, 24'($urandom));
    endtask

    // Directed table: frame_start, offset, de, h, v.
    localparam int ND = 18;
    int d_fs  [ND] = '{1,     0,  1,     0,  1,     0,  1,     0,  1,     0,
                       0,     0,  1,     0,  0,     0,  0,     0};
    int d_off [ND] = '{'h080, 'h080, 'h0C0, 'h0C0, 'h3C0, 'h3C0, 'h0FF, 'h0FF, 'h3FF, 'h3FF,
                       'h140, 'h140, 'h140, 'h140, 'h140, 'h140, 'h140, 'h140};
    int d_de  [ND] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1,
                       1, 1, 0, 1, 1, 1, 0, 1};
    int d_h   [ND] = '{0, 16, 0, 29, 0, 44, 0, 20, 0, 20,
                       21, 22, 0, 21, 15, 48, 20, 47};
    int d_v   [ND] = '{0, 16, 0, 25, 0, 44, 0, 16, 0, 16,
                       17, 17, 0, 17, 20, 20, 20, 47};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = bit'($urandom_range(0, 1));
        rom_mem['h080] = 1'b1;
        model_clear();
        drive(0, 0, 0, 0, 0, 0, 24'h0);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        reset = 1'b0;

        for (int i = 0; i < ND; i++) begin
            drive(d_fs[i] != 0, d_off[i], 1'b1, d_de[i] != 0, d_h[i], d_v[i], 24'($urandom));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, int'(offset), 1'b1, 1'b0, 0, 0, 24'($urandom));
            step();
        end

        // Blink: steady in-box pixel across several short frames.
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 4; c++) begin
                drive(c == 0, 'h080, 1'b1, 1'b1, 16, 16, 24'h123456);
                step();
            end
        end

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        // Asynchronous reset in the middle of a frame.
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_clear();
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        reset = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            drive_random();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/glyph_overlay_renderer.md
Name: glyph_overlay_renderer

Overview:
Consumes the 10-bit font offset produced by the switch decoder and renders the selected 8x8 glyph onto the outgoing HDMI pixel stream. The block drives the font ROM address, receives one bit per pixel, and muxes a foreground colour over the incoming video inside a scaled glyph box. It sits between the video timing/source path and the HDMI output serializer, on the same clock as the switch decoder.

Parameters:
X_POS, 16, left edge of glyph box in pixels
Y_POS, 16, top edge of glyph box in lines
SCALE_LOG2, 2, glyph magnification = 2^SCALE_LOG2 (box = 8<<SCALE_LOG2 square)
CNT_W, 12, width of hcount/vcount
FG_COLOR, 24'hFFFFFF, overlay colour for set glyph bits
BLINK_FRAMES, 30, frames per blink half-period (0 = no blink)

Ports:
clk_50MHz  in  1  system/pixel clock
reset  in  1  asynchronous, active-high reset
offset  in  10  glyph base address in font ROM (64 entries per glyph)
frame_start  in  1  one-cycle pulse at start of each frame (vertical blank)
blink_en  in  1  enables blinking of the glyph
de_in  in  1  data enable of incoming pixel
hcount_in  in  CNT_W  pixel x of incoming pixel
vcount_in  in  CNT_W  line y of incoming pixel
rgb_in  in  24  incoming pixel colour
rom_addr  out  10  font ROM address
rom_data  in  1  font ROM bit, valid 1 cycle after rom_addr (registered ROM)
de_out  out  1  delayed data enable
rgb_out  out  24  output pixel colour
glyph_active  out  1  high when output pixel lies inside glyph box

Behaviour:
- Reset (async assert, sync deassert by the reset-controller): rom_addr=0, de_out=0, rgb_out=0, glyph_active=0, offset_q=0, blink counter=0, blink_phase=1 (visible).
- Offset latch: offset_q <= offset only on cycle with frame_start=1; held the rest of the frame (no mid-frame glyph tearing).
- Blink: on each frame_start, if blink_en and BLINK_FRAMES!=0: counter increments; when counter==BLINK_FRAMES-1, counter<=0 and blink_phase toggles. blink_en=0 forces counter=0, blink_phase=1 on next frame_start. Same-cycle frame_start with offset change: new offset and blink update both take effect.
- Stage 0 (input cycle t): dx=hcount_in-X_POS, dy=vcount_in-Y_POS (CNT_W unsigned); in_box = de_in && hcount_in>=X_POS && hcount_in<X_POS+(8<<SCALE_LOG2) && same for v. col=dx>>SCALE_LOG2 [2:0], row=dy>>SCALE_LOG2 [2:0]. Registered: rom_addr <= offset_q + {row,col} modulo 1024 (10-bit wrap, no carry out); offset need not be 64-aligned (e.g. 0x0FF spans glyphs legitimately). in_box, de_in, rgb_in registered to stage 1. Outside box rom_addr still updates (don't-care data).
- Stage 1 (t+1): rom_data valid; stage-1 sidebands registered to stage 2.
- Stage 2 (t+2) outputs: de_out=de_in(t); glyph_active=in_box(t); rgb_out = FG_COLOR if in_box && rom_data && blink_phase else rgb_in(t). Fixed latency 2 cycles for all outputs, every cycle, no stalls.
- de_in=0: in_box=0, rgb_out passes rgb_in through delayed.
- Box clipped by screen edge: simply never matched; no wrap of hcount beyond CNT_W considered (X_POS+box < 2^CNT_W required).
- Reset mid-frame: pipeline flushes to zeros; offset_q=0 until next frame_start.

Decomposition:
- Shared package (overlay_pkg): GLYPH_W=8, GLYPH_H=8, GLYPH_WORDS=64, FONT_ADDR_W=10, RGB_W=24.
- One natural sub-module: glyph_blink_ctrl (frame counter + blink_phase, inputs frame_start/blink_en). Pipeline stays in the top.

Test Plan:
- Reset then frame_start with offset=0x080, pixel (h=16,v=16,de=1) -> rom_addr=0x080 at t+1; ROM bit 1 -> rgb_out=FFFFFF, glyph_active=1 at t+2.
- offset=0x0C0, SCALE_LOG2=2, pixel (h=16+13, v=16+9) -> col=3,row=2, rom_addr=0x0C0+0x13=0x0D3.
- offset=0x3C0, row=7,col=7 -> rom_addr=0x3FF; offset=0x0FF, row=0,col=1 -> rom_addr=0x100; offset=0x3FF, col=1 -> wraps to 0x000.
- Offset changed to 0x140 mid-frame without frame_start -> rom_addr still uses old offset; after frame_start -> 0x140 base.
- Pixel at h=X_POS-1 or h=X_POS+32, de_in=0 inside box -> glyph_active=0, rgb_out=rgb_in delayed 2 cycles, de_out follows de_in.
- blink_en=1, BLINK_FRAMES=2: in-box set pixel shows FG for 2 frames, rgb_in for 2 frames, repeats; assert reset mid-frame -> outputs 0 immediately, blink_phase=1.
